// File: rtl/conv1d_pkg.sv
// Shared encodings for the 1D convolution sequencer: FSM states and error codes.
package conv1d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD_KERNEL,
        STREAM,
        DRAIN,
        DONE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_K    = 2'd1,
        ERR_N    = 2'd2,
        ERR_TMO  = 2'd3
    } err_e;

endpackage

// File: rtl/conv1d_seq_ctrl_if.sv
// Host, core and read-out signals of the convolution sequencer.
// slave = the sequencer, master = host/core side driving it.
interface conv1d_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 16,
    parameter int ADDR_W     = 6
);
    localparam int PE_W = $clog2(NUM_PE) + 1;

    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  start_conv;
    logic                  busy;
    logic                  conv_done;
    logic                  err;
    logic [1:0]            err_code;
    logic [ADDR_W:0]       out_count;
    logic [PE_W-1:0]       active_pe_count;
    logic                  kernel_load;
    logic [DATA_WIDTH-1:0] kernel_value;
    logic [DATA_WIDTH-1:0] x_in;
    logic                  x_valid;
    logic [DATA_WIDTH-1:0] y_out;
    logic                  y_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport slave (
        input  mem_wr_en, mem_wr_addr, mem_wr_data, start_conv, y_out, y_valid, out_ready,
        output busy, conv_done, err, err_code, out_count, active_pe_count,
               kernel_load, kernel_value, x_in, x_valid, out_data, out_valid, out_last
    );

    modport master (
        output mem_wr_en, mem_wr_addr, mem_wr_data, start_conv, y_out, y_valid, out_ready,
        input  busy, conv_done, err, err_code, out_count, active_pe_count,
               kernel_load, kernel_value, x_in, x_valid, out_data, out_valid, out_last
    );

endinterface

// File: rtl/conv_buf.sv
// Register array with one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module conv_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Job sequencer for the 1D systolic convolution core: header check, kernel load,
// input stream, result capture with drain timeout, and valid/ready read-out.
module conv1d_seq_ctrl
    import conv1d_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PE        = 16,
    parameter int BUFFER_SIZE   = 64,
    parameter int ADDR_W        = 6,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    conv1d_seq_ctrl_if.slave bus
);

    localparam int CW   = ADDR_W + 1;
    localparam int PE_W = $clog2(NUM_PE) + 1;
    localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);
    localparam int HW   = DATA_WIDTH + 2;

    state_e                state_q, state_d;
    logic [CW-1:0]         k_q, k_d, n_q, n_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         rd_q, rd_d;
    logic [DATA_WIDTH-1:0] hk_q, hk_d, hn_q, hn_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [1:0]            ec_q, ec_d;
    logic [PE_W-1:0]       apc_q, apc_d;

    logic                  busy, wr_ok, cap, out_valid;
    logic                  bad_k, bad_n;
    logic [HW-1:0]         hk_w, hn_w;
    logic [CW-1:0]         r_w;
    logic [ADDR_W-1:0]     jb_raddr;
    logic [DATA_WIDTH-1:0] jb_rdata, rb_rdata;

    assign busy  = (state_q == HDR) || (state_q == LOAD_KERNEL) ||
                   (state_q == STREAM) || (state_q == DRAIN);
    assign wr_ok = bus.mem_wr_en && !busy;
    assign r_w   = n_q - k_q + CW'(1);
    assign cap   = ((state_q == STREAM) || (state_q == DRAIN)) && bus.y_valid && (cnt_q < r_w);
    assign out_valid = (state_q == DONE) && (rd_q < cnt_q);

    // K and N are shadowed on host writes so HDR can check both in one cycle
    // while the single read port stays free for the kernel/input walk.
    assign hk_w  = HW'(hk_q);
    assign hn_w  = HW'(hn_q);
    assign bad_k = (hk_q == '0) || (hk_w > HW'(NUM_PE));
    assign bad_n = (hn_w < hk_w) || (hk_w + hn_w + HW'(2) > HW'(BUFFER_SIZE));

    always_comb begin
        if (state_q == STREAM) jb_raddr = ADDR_W'(k_q + idx_q + CW'(2));
        else                   jb_raddr = ADDR_W'(idx_q + CW'(2));
    end

    conv_buf #(.DW(DATA_WIDTH), .DEPTH(BUFFER_SIZE), .AW(ADDR_W)) u_job_buf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (bus.mem_wr_addr),
        .wdata (bus.mem_wr_data),
        .raddr (jb_raddr),
        .rdata (jb_rdata)
    );

    conv_buf #(.DW(DATA_WIDTH), .DEPTH(BUFFER_SIZE), .AW(ADDR_W)) u_res_buf (
        .clk   (clk),
        .we    (cap),
        .waddr (cnt_q[ADDR_W-1:0]),
        .wdata (bus.y_out),
        .raddr (rd_q[ADDR_W-1:0]),
        .rdata (rb_rdata)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        hk_d    = hk_q;
        hn_d    = hn_q;
        tmo_d   = tmo_q;
        ec_d    = ec_q;
        apc_d   = apc_q;

        if (wr_ok && bus.mem_wr_addr == ADDR_W'(0)) hk_d = bus.mem_wr_data;
        if (wr_ok && bus.mem_wr_addr == ADDR_W'(1)) hn_d = bus.mem_wr_data;
        if (cap) cnt_d = cnt_q + CW'(1);

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (bus.start_conv) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    rd_d    = '0;
                    idx_d   = '0;
                    ec_d    = ERR_NONE;
                end else if (out_valid && bus.out_ready) begin
                    rd_d = rd_q + CW'(1);
                end
            end
            HDR: begin
                if (bad_k) begin
                    state_d = ERROR;
                    ec_d    = ERR_K;
                end else if (bad_n) begin
                    state_d = ERROR;
                    ec_d    = ERR_N;
                end else begin
                    state_d = LOAD_KERNEL;
                    k_d     = CW'(hk_q);
                    n_d     = CW'(hn_q);
                    apc_d   = PE_W'(hk_q);
                    idx_d   = '0;
                end
            end
            LOAD_KERNEL: begin
                if (idx_q == k_q - CW'(1)) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            STREAM: begin
                tmo_d = '0;
                if (idx_q == n_q - CW'(1)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            DRAIN: begin
                // Timeout fires on the DRAIN_TIMEOUT-th quiet cycle.
                if (cnt_q == r_w) begin
                    state_d = DONE;
                end else if (bus.y_valid) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    state_d = ERROR;
                    ec_d    = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            hk_q    <= '0;
            hn_q    <= '0;
            tmo_q   <= '0;
            ec_q    <= ERR_NONE;
            apc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            hk_q    <= hk_d;
            hn_q    <= hn_d;
            tmo_q   <= tmo_d;
            ec_q    <= ec_d;
            apc_q   <= apc_d;
        end
    end

    // Data outputs are gated by their strobes so everything reads 0 outside use.
    assign bus.busy            = busy;
    assign bus.conv_done       = (state_q == DONE);
    assign bus.err             = (state_q == ERROR);
    assign bus.err_code        = ec_q;
    assign bus.out_count       = cnt_q;
    assign bus.active_pe_count = apc_q;
    assign bus.kernel_load     = (state_q == LOAD_KERNEL);
    assign bus.kernel_value    = (state_q == LOAD_KERNEL) ? jb_rdata : '0;
    assign bus.x_valid         = (state_q == STREAM);
    assign bus.x_in            = (state_q == STREAM) ? jb_rdata : '0;
    assign bus.out_valid       = out_valid;
    assign bus.out_data        = out_valid ? rb_rdata : '0;
    assign bus.out_last        = out_valid && (rd_q == cnt_q - CW'(1));

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Directed bench for conv1d_seq_ctrl: normal job, header errors, drain timeout,
// stalled read-out, surplus results, and reset during streaming.
module tb_conv1d_seq_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   kl_cnt;
    int   xv_cnt;

    conv1d_seq_ctrl_if #(.DATA_WIDTH(8), .NUM_PE(16), .ADDR_W(6)) bus ();

    conv1d_seq_ctrl #(
        .DATA_WIDTH(8), .NUM_PE(16), .BUFFER_SIZE(64), .ADDR_W(6), .DRAIN_TIMEOUT(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.kernel_load) kl_cnt <= kl_cnt + 1;
        if (bus.x_valid)     xv_cnt <= xv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int data);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = 6'(addr);
        bus.mem_wr_data = 8'(data);
        tick();
        bus.mem_wr_en   = 1'b0;
    endtask

    task automatic load_job_a();
        wr(0, 3);
        wr(1, 8);
        wr(2, 2);
        wr(3, 3);
        wr(4, 4);
        for (int i = 0; i < 8; i++) wr(5 + i, i + 1);
    endtask

    task automatic start();
        bus.start_conv = 1'b1;
        tick();
        bus.start_conv = 1'b0;
    endtask

    // Job A (K=3, N=8) from start pulse up to the first DRAIN cycle.
    task automatic run_to_drain();
        start();
        chk("hdr_busy", bus.busy, 1);
        chk("hdr_kl", bus.kernel_load, 0);
        tick();
        chk("apc", bus.active_pe_count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("kl", bus.kernel_load, 1);
            chk("kv", bus.kernel_value, 2 + i);
            chk("kl_xv", bus.x_valid, 0);
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            chk("xv", bus.x_valid, 1);
            chk("xin", bus.x_in, j + 1);
            chk("xv_kl", bus.kernel_load, 0);
            tick();
        end
        chk("drain_xv", bus.x_valid, 0);
        chk("drain_busy", bus.busy, 1);
    endtask

    task automatic send_y(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.y_valid = 1'b1;
            bus.y_out   = 8'(base + i);
            tick();
        end
        bus.y_valid = 1'b0;
        bus.y_out   = '0;
    endtask

    task automatic read_all(input int n, input int base, input logic [3:0] pat);
        int k;
        int p;
        k = 0;
        p = 0;
        while (k < n && p < 60) begin
            bus.out_ready = pat[p % 4];
            chk("rd_valid", bus.out_valid, 1);
            chk("rd_data", bus.out_data, base + k);
            chk("rd_last", bus.out_last, (k == n - 1) ? 1 : 0);
            tick();
            if (pat[p % 4]) k++;
            p++;
        end
        bus.out_ready = 1'b0;
        chk("rd_count", k, n);
        chk("rd_empty", bus.out_valid, 0);
    endtask

    int ek [4] = '{0, 17, 3, 3};
    int en [4] = '{8, 8, 2, 60};
    int ec [4] = '{1, 1, 2, 2};

    initial begin
        int kl0;
        int xv0;
        clk = 1'b0;
        reset = 1'b1;
        errors = 0;
        checks = 0;
        kl_cnt = 0;
        xv_cnt = 0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.start_conv = 1'b0;
        bus.y_out = '0;
        bus.y_valid = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.conv_done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_cnt", bus.out_count, 0);
        chk("rst_apc", bus.active_pe_count, 0);
        chk("rst_oval", bus.out_valid, 0);
        reset = 1'b0;
        tick();

        // Normal job with stalled read-out
        load_job_a();
        run_to_drain();
        send_y(6, 10);
        tick();
        chk("a_done", bus.conv_done, 1);
        chk("a_cnt", bus.out_count, 6);
        chk("a_busy", bus.busy, 0);
        chk("a_err", bus.err, 0);
        read_all(6, 10, 4'b1001);

        // Surplus results are discarded
        run_to_drain();
        send_y(8, 10);
        chk("x_done", bus.conv_done, 1);
        chk("x_cnt", bus.out_count, 6);
        read_all(6, 10, 4'b1111);

        // Drain timeout after 4 of 6
        run_to_drain();
        send_y(4, 20);
        repeat (31) tick();
        chk("tmo_early", bus.err, 0);
        tick();
        chk("tmo_err", bus.err, 1);
        chk("tmo_code", bus.err_code, 3);
        chk("tmo_cnt", bus.out_count, 4);
        chk("tmo_busy", bus.busy, 0);

        // Bad headers
        for (int c = 0; c < 4; c++) begin
            wr(0, ek[c]);
            wr(1, en[c]);
            kl0 = kl_cnt;
            xv0 = xv_cnt;
            start();
            chk("bh_code_clr", bus.err_code, 0);
            tick();
            chk("bh_err", bus.err, 1);
            chk("bh_code", bus.err_code, ec[c]);
            chk("bh_kl", kl_cnt - kl0, 0);
            chk("bh_xv", xv_cnt - xv0, 0);
        end

        // Reset mid-STREAM; a write while busy must be dropped
        wr(0, 3);
        wr(1, 8);
        start();
        repeat (4) tick();
        chk("ms_xv", bus.x_valid, 1);
        wr(2, 99);
        chk("ms_xv2", bus.x_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_xv", bus.x_valid, 0);
        chk("ar_xin", bus.x_in, 0);
        chk("ar_kl", bus.kernel_load, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_err", bus.err, 0);
        chk("ar_cnt", bus.out_count, 0);
        chk("ar_apc", bus.active_pe_count, 0);
        tick();
        reset = 1'b0;
        wr(0, 3);
        wr(1, 8);
        run_to_drain();
        send_y(6, 30);
        tick();
        chk("r_done", bus.conv_done, 1);
        chk("r_cnt", bus.out_count, 6);
        read_all(6, 30, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv1d_seq_ctrl.md
Name: conv1d_seq_ctrl

Overview:
Parametrised next-generation sequencer for the 1D systolic convolution core. It holds a host-written job buffer with an explicit header, then loads the kernel and streams the input to the core. It captures a known number of core results and returns them over a valid/ready read port. Unlike the previous top, it uses explicit lengths instead of X-detection, validates the header, has a drain timeout with an error code, re-arms without reset, and applies back-pressure on read-out.

Parameters:
DATA_WIDTH, 8, sample/coefficient width
NUM_PE, 16, maximum kernel length K supported by the core
BUFFER_SIZE, 64, depth of job buffer and result buffer
ADDR_W, 6, address width; must equal clog2(BUFFER_SIZE)
DRAIN_TIMEOUT, 32, cycles allowed in DRAIN without y_valid before error

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
mem_wr_en  in  1  host write strobe into job buffer
mem_wr_addr  in  ADDR_W  job buffer address
mem_wr_data  in  DATA_WIDTH  job buffer data
start_conv  in  1  one-cycle job start pulse
busy  out  1  high from HDR through DRAIN
conv_done  out  1  high in DONE
err  out  1  high in ERROR
err_code  out  2  1=bad K, 2=bad N, 3=drain timeout
out_count  out  ADDR_W+1  results captured in current job
active_pe_count  out  clog2(NUM_PE)+1  K, to core
kernel_load  out  1  coefficient strobe, to core
kernel_value  out  DATA_WIDTH  coefficient, to core
x_in  out  DATA_WIDTH  input sample, to core
x_valid  out  1  sample strobe, to core
y_out  in  DATA_WIDTH  result from core
y_valid  in  1  result strobe from core
out_data  out  DATA_WIDTH  read-out data
out_valid  out  1  read-out valid
out_last  out  1  marks final result, qualified by out_valid
out_ready  in  1  read-out accept

Behaviour:
- Reset: all outputs 0, state IDLE, all pointers 0. Buffer contents are not reset.
- Job layout: addr0=K, addr1=N, addr2..K+1=kernel, addr K+2..K+1+N=input. Expected results R=N-K+1.
- Host writes are accepted only when busy=0; writes while busy are dropped.
- IDLE/DONE/ERROR: start_conv moves to HDR. It clears out_count, rd_ptr and err_code. start_conv while busy is ignored.
- HDR, 1 cycle: latch K and N.
  - K==0 or K>NUM_PE -> ERROR, code 1.
  - N<K or K+N+2>BUFFER_SIZE -> ERROR, code 2.
  - Otherwise -> LOAD_KERNEL, and active_pe_count=K.
- LOAD_KERNEL: exactly K consecutive cycles with kernel_load=1, kernel_value=mem[2+i], i=0..K-1. Then -> STREAM with no gap cycle.
- STREAM: exactly N consecutive cycles with x_valid=1, x_in=mem[K+2+j]. Then x_valid=0 and -> DRAIN.
- Capture runs in STREAM and DRAIN. Each y_valid while out_count<R writes y_out to result[out_count] and increments out_count. Extra results are discarded.
- DRAIN:
  - out_count==R -> DONE.
  - Timeout counter resets on each y_valid. Reaching DRAIN_TIMEOUT -> ERROR, code 3.
- Read-out is legal in DONE only.
  - out_valid=1 while rd_ptr<out_count; out_data=result[rd_ptr].
  - The transfer occurs when out_valid&out_ready; rd_ptr then increments.
  - out_data and out_valid hold stable while out_ready=0.
  - out_last=1 when rd_ptr==out_count-1.
- Reset mid-job: returns to IDLE immediately; core strobes drop to 0 in the same cycle (async).

Decomposition:
- Package conv1d_pkg: state encoding (IDLE, HDR, LOAD_KERNEL, STREAM, DRAIN, DONE, ERROR) and err_code constants (ERR_NONE=0, ERR_K=1, ERR_N=2, ERR_TMO=3).
- One sub-module, conv_buf: a register array with one synchronous write port and one combinational read port. It is instantiated twice: job buffer and result buffer.

Test Plan:
- K=3, N=8, kernel 2,3,4, inputs 1..8; bench core model returns 6 results 10..15 -> kernel_load high 3 consecutive cycles carrying 2,3,4; x_valid high 8 consecutive cycles carrying 1..8; conv_done; out_count=6.
- Error headers: K=0 -> err=1, err_code=1. K=17 -> err_code=1. K=3, N=2 -> err_code=2. K=3, N=60 -> err_code=2. In all cases no kernel_load or x_valid pulse occurs.
- Core model withholds results after 4 of 6 -> err_code=3 exactly 32 cycles after the last y_valid; out_count=4.
- Read-out of the 6 results with out_ready toggling 1,0,0,1 -> data 10..15 in order, each held stable while stalled, out_last only on 15.
- Core model sends 8 results for R=6 -> only 10..15 stored, out_count=6.
- Reset asserted mid-STREAM, then a new job started without further reset -> x_valid drops asynchronously, state IDLE, outputs 0; the restarted job completes correctly.
